// File: rtl/hdmi_di_packet_rx.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_di_packet_rx
// Purpose  : Reassembles 32-pixel HDMI data-island packets from TERC4 nibbles.
//            Optional BCH check: define HDMI_DI_ECC_CHECK_EN.
// Revision : 1.0
// ============================================================================
module hdmi_di_packet_rx #(
  parameter int PKT_LEN = 32,
  parameter int CNT_W   = 5
) (
  input  logic        p_clk,
  input  logic        reset,
  input  logic        di_active,
  input  logic [3:0]  blue_di,
  input  logic [3:0]  green_di,
  input  logic [3:0]  red_di,
  output logic        pkt_valid,
  output logic [31:0] pkt_header,
  output logic [63:0] pkt_sub0,
  output logic [63:0] pkt_sub1,
  output logic [63:0] pkt_sub2,
  output logic [63:0] pkt_sub3,
  output logic        frame_err,
  output logic [4:0]  ecc_err,
  output logic [7:0]  pkt_count
);

  localparam logic [CNT_W-1:0] C_LAST_PIX = CNT_W'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [30:0]      r_hdr_asm;
  logic [61:0]      r_sub_asm [4];

  logic             w_start;
  logic             w_take;
  logic             w_last;
  logic [31:0]      w_hdr_next;
  logic [3:0][63:0] w_sub_next;
  logic             w_unused_sync;

  // hsync/vsync ride along on blue[1:0] but carry nothing for packet assembly
  assign w_unused_sync = ^blue_di[1:0];

  always_comb begin
    w_start    = di_active & ~blue_di[3];
    w_take     = di_active & (w_start | ((r_state == ST_COLLECT) && (r_cnt != '0)));
    w_last     = w_take & ~w_start & (r_cnt == C_LAST_PIX);
    w_hdr_next = {blue_di[2], r_hdr_asm};
  end

  // Shift in from the top so pixel 0 ends up in bit 0 after a full packet
  generate
    for (genvar k = 0; k < 4; k++) begin : g_sub
      assign w_sub_next[k] = {red_di[k], green_di[k], r_sub_asm[k]};
    end
  endgenerate

  always_ff @(posedge p_clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_hdr_asm  <= '0;
      for (int k = 0; k < 4; k++) r_sub_asm[k] <= '0;
      pkt_valid  <= 1'b0;
      frame_err  <= 1'b0;
      pkt_header <= '0;
      pkt_sub0   <= '0;
      pkt_sub1   <= '0;
      pkt_sub2   <= '0;
      pkt_sub3   <= '0;
      pkt_count  <= '0;
    end else begin
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;

      if (w_take) begin
        r_hdr_asm <= w_hdr_next[31:1];
        for (int k = 0; k < 4; k++) r_sub_asm[k] <= w_sub_next[k][63:2];
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cnt   <= C_ONE;
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (!di_active) begin
            // Counter at 0 means the island ended cleanly on a packet boundary
            frame_err <= (r_cnt != '0);
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end else if (w_start) begin
            frame_err <= (r_cnt != '0);
            r_cnt     <= C_ONE;
          end else if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else if (w_last) begin
            r_cnt      <= '0;
            pkt_valid  <= 1'b1;
            pkt_header <= w_hdr_next;
            pkt_sub0   <= w_sub_next[0];
            pkt_sub1   <= w_sub_next[1];
            pkt_sub2   <= w_sub_next[2];
            pkt_sub3   <= w_sub_next[3];
            pkt_count  <= pkt_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HDMI_DI_ECC_CHECK_EN
  localparam logic [CNT_W-1:0] C_HDR_DATA_PIX = CNT_W'(24);
  localparam logic [CNT_W-1:0] C_SUB_DATA_PIX = CNT_W'(28);

  function automatic logic [7:0] bch_step(input logic [7:0] s, input logic d);
    logic fb;
    fb = d ^ s[0];
    return (s >> 1) ^ (fb ? 8'h83 : 8'h00);
  endfunction

  logic [CNT_W-1:0] w_pix_idx;
  logic [7:0]       r_hdr_lfsr;
  logic [7:0]       w_hdr_lfsr_base;
  logic [7:0]       w_hdr_lfsr_next;
  logic [3:0][7:0]  r_sub_lfsr;
  logic [3:0][7:0]  w_sub_lfsr_base;
  logic [3:0][7:0]  w_sub_lfsr_next;
  logic [4:0]       w_ecc_err;
  logic [4:0]       r_ecc_err;

  // A start nibble always restarts the LFSRs, even mid-packet
  always_comb begin
    w_pix_idx       = w_start ? '0 : r_cnt;
    w_hdr_lfsr_base = w_start ? 8'h00 : r_hdr_lfsr;
    w_hdr_lfsr_next = (w_pix_idx < C_HDR_DATA_PIX) ?
                      bch_step(w_hdr_lfsr_base, blue_di[2]) : w_hdr_lfsr_base;
  end

  assign w_ecc_err[0] = (w_hdr_lfsr_next != w_hdr_next[31:24]);

  generate
    for (genvar k = 0; k < 4; k++) begin : g_sub_ecc
      assign w_sub_lfsr_base[k] = w_start ? 8'h00 : r_sub_lfsr[k];
      assign w_sub_lfsr_next[k] = (w_pix_idx < C_SUB_DATA_PIX) ?
                                  bch_step(bch_step(w_sub_lfsr_base[k], green_di[k]), red_di[k]) :
                                  w_sub_lfsr_base[k];
      assign w_ecc_err[1+k]     = (w_sub_lfsr_next[k] != w_sub_next[k][63:56]);
    end
  endgenerate

  always_ff @(posedge p_clk) begin
    if (reset) begin
      r_hdr_lfsr <= '0;
      r_sub_lfsr <= '0;
      r_ecc_err  <= '0;
    end else begin
      if (w_take) begin
        r_hdr_lfsr <= w_hdr_lfsr_next;
        r_sub_lfsr <= w_sub_lfsr_next;
      end
      if (w_last) r_ecc_err <= w_ecc_err;
    end
  end

  assign ecc_err = r_ecc_err;
`else
  assign ecc_err = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdmi_di_packet_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_di_packet_rx
// Purpose  : Randomized self-checking bench with a packet-level reference model.
// Revision : 1.0
// ============================================================================
module tb_hdmi_di_packet_rx;

  logic        p_clk = 1'b0;
  logic        reset;
  logic        di_active;
  logic [3:0]  blue_di, green_di, red_di;
  logic        pkt_valid, frame_err;
  logic [31:0] pkt_header;
  logic [63:0] pkt_sub0, pkt_sub1, pkt_sub2, pkt_sub3;
  logic [4:0]  ecc_err;
  logic [7:0]  pkt_count;

  hdmi_di_packet_rx #(.PKT_LEN(32), .CNT_W(5)) dut (
    .p_clk(p_clk), .reset(reset), .di_active(di_active),
    .blue_di(blue_di), .green_di(green_di), .red_di(red_di),
    .pkt_valid(pkt_valid), .pkt_header(pkt_header),
    .pkt_sub0(pkt_sub0), .pkt_sub1(pkt_sub1), .pkt_sub2(pkt_sub2), .pkt_sub3(pkt_sub3),
    .frame_err(frame_err), .ecc_err(ecc_err), .pkt_count(pkt_count)
  );

  always #5 p_clk = ~p_clk;

  typedef struct packed {
    logic [3:0][63:0] sub;
    logic [31:0]      hdr;
  } pkt_t;

  pkt_t       exp_q[$];
  int         exp_edge_q[$];
  pkt_t       last_good = '0;
  pkt_t       mon_e;
  int         mon_edge;
  int         cyc = 0;
  int         n_checks = 0, n_errors = 0;
  int         n_ferr = 0, exp_ferr = 0;
  logic [7:0] exp_count = 8'd0;

  always @(posedge p_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Serial BCH over n data bits, LSB first
  function automatic logic [7:0] bch(input logic [55:0] d, input int n);
    logic [7:0] s;
    logic       fb;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = d[i] ^ s[0];
      s  = (s >> 1) ^ (fb ? 8'h83 : 8'h00);
    end
    return s;
  endfunction

  function automatic pkt_t seal(input pkt_t p);
    pkt_t r;
    r = p;
    r.hdr[31:24] = bch({32'h0, p.hdr[23:0]}, 24);
    for (int k = 0; k < 4; k++) r.sub[k][63:56] = bch(p.sub[k][55:0], 56);
    return r;
  endfunction

  function automatic logic [4:0] exp_ecc(input pkt_t p);
    logic [4:0] e;
    e = 5'b0;
`ifdef HDMI_DI_ECC_CHECK_EN
    e[0] = (bch({32'h0, p.hdr[23:0]}, 24) != p.hdr[31:24]);
    for (int k = 0; k < 4; k++) e[k+1] = (bch(p.sub[k][55:0], 56) != p.sub[k][63:56]);
`else
    e[0] = p.hdr[0] & 1'b0;
`endif
    return e;
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p = '0;
    p.hdr[23:0] = 24'($urandom);
    for (int k = 0; k < 4; k++) p.sub[k][55:0] = {24'($urandom), 32'($urandom)};
    return seal(p);
  endfunction

  task automatic drive_pixel(input pkt_t p, input int i);
    di_active = 1'b1;
    blue_di   = {(i == 0) ? 1'b0 : 1'b1, p.hdr[i], 2'($urandom)};
    for (int k = 0; k < 4; k++) begin
      green_di[k] = p.sub[k][2*i];
      red_di[k]   = p.sub[k][2*i+1];
    end
    @(posedge p_clk); #1;
  endtask

  task automatic send(input pkt_t p, input int npix);
    for (int i = 0; i < npix; i++) drive_pixel(p, i);
    if (npix == 32) begin
      exp_q.push_back(p);
      exp_edge_q.push_back(cyc);
      exp_count = exp_count + 8'd1;
    end
  endtask

  task automatic idle(input int n);
    di_active = 1'b0;
    blue_di   = 4'($urandom);
    green_di  = 4'($urandom);
    red_di    = 4'($urandom);
    repeat (n) begin @(posedge p_clk); #1; end
  endtask

  always @(negedge p_clk) begin
    if (frame_err) n_ferr++;
    if (pkt_valid) begin
      check("valid_vs_ferr", 64'(frame_err), 64'd0);
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(pkt_valid), 64'd0);
      end else begin
        mon_e    = exp_q.pop_front();
        mon_edge = exp_edge_q.pop_front();
        check("latency", 64'(cyc), 64'(mon_edge));
        check("header", 64'(pkt_header), 64'(mon_e.hdr));
        check("sub0", pkt_sub0, mon_e.sub[0]);
        check("sub1", pkt_sub1, mon_e.sub[1]);
        check("sub2", pkt_sub2, mon_e.sub[2]);
        check("sub3", pkt_sub3, mon_e.sub[3]);
        check("ecc", 64'(ecc_err), 64'(exp_ecc(mon_e)));
        last_good = mon_e;
      end
    end
  end

  initial begin
    pkt_t p;
    int   mode, sel;

    reset = 1'b1;
    idle(3);
    check("rst_valid", 64'(pkt_valid), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    check("rst_ecc", 64'(ecc_err), 64'd0);
    check("rst_count", 64'(pkt_count), 64'd0);
    check("rst_header", 64'(pkt_header), 64'd0);
    check("rst_sub0", pkt_sub0, 64'd0);
    reset = 1'b0;
    idle(2);

    // Known packet
    p = '0;
    p.hdr[23:0]     = 24'h0D0282;
    p.sub[0][55:0]  = 56'h00000000001A7C;
    p = seal(p);
    send(p, 32);
    idle(3);
    check("t1_count", 64'(pkt_count), 64'd1);
    check("t1_hdr_data", 64'(pkt_header[23:0]), 64'h0D0282);
    check("t1_ecc", 64'(ecc_err), 64'd0);

    // Back-to-back pair, then one after a gap
    send(rand_pkt(), 32);
    send(rand_pkt(), 32);
    idle(6);
    send(rand_pkt(), 32);
    idle(3);
    check("t2_count", 64'(pkt_count), 64'(exp_count));
    check("t2_ferr", 64'(n_ferr), 64'(exp_ferr));

    // Start nibble at pixel 17
    send(rand_pkt(), 17);
    exp_ferr++;
    send(rand_pkt(), 32);
    idle(3);
    check("t3_ferr", 64'(n_ferr), 64'(exp_ferr));
    check("t3_count", 64'(pkt_count), 64'(exp_count));

    // Island ends after pixel 20
    send(rand_pkt(), 21);
    exp_ferr++;
    idle(4);
    check("t4_ferr", 64'(n_ferr), 64'(exp_ferr));
    check("t4_hold_hdr", 64'(pkt_header), 64'(last_good.hdr));
    check("t4_hold_sub3", pkt_sub3, last_good.sub[3]);
    check("t4_count", 64'(pkt_count), 64'(exp_count));

    // Reset at pixel 10
    p = rand_pkt();
    send(p, 10);
    reset = 1'b1;
    for (int i = 10; i < 13; i++) begin
      drive_pixel(p, i);
      check("t5_rst_valid", 64'(pkt_valid), 64'd0);
      check("t5_rst_ferr", 64'(frame_err), 64'd0);
    end
    reset = 1'b0;
    exp_count = 8'd0;
    last_good = '0;
    idle(1);
    check("t5_count0", 64'(pkt_count), 64'd0);
    check("t5_hdr0", 64'(pkt_header), 64'd0);
    check("t5_sub0", pkt_sub0, 64'd0);
    send(rand_pkt(), 32);
    idle(3);
    check("t5_count1", 64'(pkt_count), 64'd1);
    check("t5_ferr", 64'(n_ferr), 64'(exp_ferr));

    // Corrupted header bit 5 and sub2 bit 40
    p = rand_pkt();
    p.hdr[5]     = ~p.hdr[5];
    p.sub[2][40] = ~p.sub[2][40];
    send(p, 32);
    idle(3);
`ifdef HDMI_DI_ECC_CHECK_EN
    check("t6_ecc_flip", 64'(ecc_err), 64'h09);
`else
    check("t6_ecc_flip", 64'(ecc_err), 64'h00);
`endif

    // Randomized traffic
    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(0, 9);
      p = rand_pkt();
      if ($urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 4);
        if (sel == 4) p.hdr[$urandom_range(0, 31)] ^= 1'b1;
        else          p.sub[sel][$urandom_range(0, 63)] ^= 1'b1;
      end
      if (mode <= 6) begin
        send(p, 32);
      end else if (mode <= 8) begin
        send(p, $urandom_range(1, 31));
        exp_ferr++;
        send(rand_pkt(), 32);
      end else begin
        send(p, $urandom_range(1, 31));
        exp_ferr++;
        idle($urandom_range(1, 3));
      end
      idle($urandom_range(0, 2));
    end
    idle(4);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    check("final_ferr", 64'(n_ferr), 64'(exp_ferr));
    check("final_count", 64'(pkt_count), 64'(exp_count));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
